// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: default geometry shared by the FIFO and its storage
package sync_fifo_pkg;
  localparam int default_data_width = 16;
  localparam int default_addr_width = 2;
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: word array with synchronous write, asynchronous read and reset-to-zero
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int data_width = default_data_width,
  parameter int addr_width = default_addr_width
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [addr_width-1:0] waddr,
  input  logic [data_width-1:0] wdata,
  input  logic [addr_width-1:0] raddr,
  output logic [data_width-1:0] rdata
);
  localparam int depth = 1 << addr_width;
  logic [data_width-1:0] mem [depth];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < depth; i++) mem[i] <= '0;
    else if (we)
      mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO with registered full/empty flags
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int data_width = default_data_width,
  parameter int addr_width = default_addr_width
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [data_width-1:0] wdata,
  input  logic                  winc,
  input  logic                  rinc,
  output logic [data_width-1:0] rdata,
  output logic                  wfull,
  output logic                  rempty
);
  logic [addr_width:0] wptr, rptr, wptr_nx, rptr_nx;
  logic wr_en, rd_en;
  assign wr_en = winc & ~wfull;
  assign rd_en = rinc & ~rempty;
  assign wptr_nx = wptr + {{addr_width{1'b0}}, wr_en};
  assign rptr_nx = rptr + {{addr_width{1'b0}}, rd_en};
  // flags come from next-state pointers so they move on the same edge as the pointers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      rempty <= 1'b1;
      wfull <= 1'b0;
    end else begin
      wptr <= wptr_nx;
      rptr <= rptr_nx;
      rempty <= wptr_nx == rptr_nx;
      wfull <= (wptr_nx[addr_width-1:0] == rptr_nx[addr_width-1:0]) && (wptr_nx[addr_width] != rptr_nx[addr_width]);
    end
  sync_fifo_mem #(.data_width(data_width), .addr_width(addr_width)) u_mem (
    .clk(clk),
    .rst_n(rst_n),
    .we(wr_en),
    .waddr(wptr[addr_width-1:0]),
    .wdata(wdata),
    .raddr(rptr[addr_width-1:0]),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed self-checking bench for sync_fifo with 16-bit words, depth 4
module tb_sync_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] wdata = '0;
  logic winc = 1'b0;
  logic rinc = 1'b0;
  logic [15:0] rdata;
  logic wfull, rempty;
  int tests = 0;
  int failed = 0;

  sync_fifo #(.data_width(16), .addr_width(2)) dut (
    .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .rinc(rinc),
    .rdata(rdata), .wfull(wfull), .rempty(rempty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic w, input logic [15:0] d, input logic r);
    winc = w;
    wdata = d;
    rinc = r;
    @(posedge clk);
    #1;
    winc = 1'b0;
    rinc = 1'b0;
  endtask

  initial begin
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_rempty", 16'(rempty), 16'h1);
    chk("reset_wfull", 16'(wfull), 16'h0);
    chk("reset_rdata", rdata, 16'h0000);

    step(1, 16'h0001, 0);
    chk("fill1_rempty", 16'(rempty), 16'h0);
    chk("fill1_rdata", rdata, 16'h0001);
    chk("fill1_wfull", 16'(wfull), 16'h0);
    step(1, 16'h0002, 0);
    step(1, 16'h000A, 0);
    chk("fill3_wfull", 16'(wfull), 16'h0);
    step(1, 16'h000B, 0);
    chk("fill4_wfull", 16'(wfull), 16'h1);

    step(1, 16'h000C, 0);
    chk("ovf_wfull", 16'(wfull), 16'h1);
    chk("ovf_head", rdata, 16'h0001);
    step(0, 16'h0000, 1);
    chk("rd1_wfull", 16'(wfull), 16'h0);
    chk("rd1_head", rdata, 16'h0002);
    step(0, 16'h0000, 1);
    chk("rd2_head", rdata, 16'h000A);
    step(0, 16'h0000, 1);
    chk("rd3_head", rdata, 16'h000B);
    chk("rd3_rempty", 16'(rempty), 16'h0);
    step(0, 16'h0000, 1);
    chk("rd4_rempty", 16'(rempty), 16'h1);

    for (int i = 0; i < 3; i++) begin
      step(0, 16'h0000, 1);
      chk("unf_rempty", 16'(rempty), 16'h1);
      chk("unf_wfull", 16'(wfull), 16'h0);
    end
    step(1, 16'h0055, 0);
    chk("unf_wr_rdata", rdata, 16'h0055);
    chk("unf_wr_rempty", 16'(rempty), 16'h0);

    step(1, 16'h0056, 0);
    step(1, 16'h0100, 1);
    chk("sim0_head", rdata, 16'h0056);
    chk("sim0_rempty", 16'(rempty), 16'h0);
    chk("sim0_wfull", 16'(wfull), 16'h0);
    for (int i = 1; i < 6; i++) begin
      step(1, 16'h0100 + 16'(i), 1);
      chk("sim_head", rdata, 16'h0100 + 16'(i - 1));
      chk("sim_rempty", 16'(rempty), 16'h0);
      chk("sim_wfull", 16'(wfull), 16'h0);
    end
    step(0, 16'h0000, 1);
    chk("drain1_head", rdata, 16'h0105);
    step(0, 16'h0000, 1);
    chk("drain2_rempty", 16'(rempty), 16'h1);

    for (int i = 0; i < 4; i++) step(1, 16'h0200 + 16'(i), 0);
    chk("corner_full", 16'(wfull), 16'h1);
    step(1, 16'h02FF, 1);
    chk("fullrw_wfull", 16'(wfull), 16'h0);
    chk("fullrw_head", rdata, 16'h0201);
    step(0, 16'h0000, 1);
    chk("fullrw_rd1", rdata, 16'h0202);
    step(0, 16'h0000, 1);
    chk("fullrw_rd2", rdata, 16'h0203);
    step(0, 16'h0000, 1);
    chk("fullrw_empty", 16'(rempty), 16'h1);
    step(1, 16'h0300, 1);
    chk("emptyrw_rempty", 16'(rempty), 16'h0);
    chk("emptyrw_rdata", rdata, 16'h0300);

    step(1, 16'h0301, 0);
    step(1, 16'h0302, 0);
    chk("pre_rst_head", rdata, 16'h0300);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_rempty", 16'(rempty), 16'h1);
    chk("arst_wfull", 16'(wfull), 16'h0);
    chk("arst_rdata", rdata, 16'h0000);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(1, 16'h0077, 0);
    chk("post_rst_rdata", rdata, 16'h0077);
    chk("post_rst_rempty", 16'(rempty), 16'h0);
    step(0, 16'h0000, 1);
    chk("post_rst_drain", 16'(rempty), 16'h1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock first-in/first-out buffer of 2**addr_width words, each data_width bits wide.
- Decouples a word producer from a word consumer inside the CCD readout firmware.
- Head word is presented combinationally on rdata (first-word fall-through).
- Registered full/empty flags throttle both sides.

Parameters:
- data_width, 16, bits per stored word.
- addr_width, 2, log2 of depth; depth = 2**addr_width (default 4 words).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wdata  input  data_width  word to write.
- winc  input  1  write request, sampled on rising clk.
- rinc  input  1  read (pop) request, sampled on rising clk.
- rdata  output  data_width  word at head of FIFO (oldest unread).
- wfull  output  1  registered full flag.
- rempty  output  1  registered empty flag.

Behaviour:
- Storage: array of 2**addr_width words.
- wptr and rptr are addr_width+1 bits wide. The low addr_width bits address memory; the MSB is the wrap bit.
- Reset (rst_n low, asynchronous, any time including mid-operation):
  - wptr = rptr = 0; all memory words = 0.
  - rempty = 1, wfull = 0, rdata = 0.
  - All held data is discarded.
  - Release is synchronous to the next rising clk; no operation occurs while rst_n is low.
- Write: on rising clk with winc=1 and wfull=0:
  - mem[wptr[addr_width-1:0]] <= wdata.
  - wptr increments by 1 (modulo 2**(addr_width+1)).
- Write while wfull=1 is ignored; memory and pointers are unchanged. Decided: this holds even if rinc=1 in the same cycle.
- Read: on rising clk with rinc=1 and rempty=0, rptr increments by 1.
- Read while rempty=1 is ignored. Decided: this holds even if winc=1 in the same cycle; the write is still accepted.
- rdata = mem[rptr[addr_width-1:0]] combinationally.
  - The valid head word is visible with zero latency once rempty=0.
  - When rempty=1, rdata is the stale word at rptr and carries no meaning.
- Write-to-read latency: a word written at edge N makes rempty deassert at edge N, so it is readable from that edge.
- Flags are registered and computed from next-state pointers, so they update on the same edge as the pointer change.
  - rempty_next = (wptr_next == rptr_next).
  - wfull_next = (low bits equal) and (MSBs differ).
- Simultaneous accepted read and write: occupancy is unchanged and flags hold. The read takes the old head word; the write lands at the tail.
- Wrap-around: pointers wrap naturally. FIFO order is preserved across any number of wraps.
- Full and empty are never both 1.
- Occupancy (wptr − rptr) is always between 0 and 2**addr_width.

Decomposition:
- No shared package is required. depth = 1 << addr_width is a local constant.
- A natural sub-module is sync_fifo_mem: a 2**addr_width × data_width array with a synchronous write port, an asynchronous read port and reset-to-zero.
- Pointer and flag logic stay in sync_fifo.

Test Plan:
- Reset: assert rst_n=0 for 10 ns, then release → rempty=1, wfull=0, rdata=0x0000.
- Fill: write 0x0001, 0x0002, 0x000A, 0x000B on four consecutive edges → after the first write rempty=0 and rdata=0x0001; after the fourth wfull=1.
- Overflow: with the FIFO full, write 0x000C → ignored, wfull stays 1. Then read four times → rdata sequence 0x0001, 0x0002, 0x000A, 0x000B; wfull=0 after the first read; rempty=1 after the fourth.
- Underflow: with the FIFO empty, assert rinc for 3 cycles → pointers unchanged, rempty stays 1. Then write 0x0055 → rdata=0x0055.
- Simultaneous and wrap: hold 2 words, then assert winc+rinc together for 6 cycles with wdata=0x0100..0x0105 → flags constant, output order continuous through the pointer wrap; on the full and empty corners, the write and read respectively are ignored per the rules above.
- Reset mid-operation: with 3 words stored, pulse rst_n low between clock edges → flags and rdata reset immediately (asynchronously); a subsequent write of 0x0077 is read back first.
